// File: rtl/timer_ctrl.sv
// Timer control FSM: arms the timer datapath, gates counting, and turns expiries into a level irq.
// Optional prescaler on the count enable is built when TIMER_CTRL_PRESCALE_EN is defined.
module timer_ctrl #(
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned EXP_W   = 16,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               periodic,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               irq_ack,
  input  logic               done,
  output logic               count,
  output logic               rst_counter,
  output logic [CNT_W-1:0]   cmp_value,
  output logic               irq,
  output logic               overrun,
  output logic               busy,
  output logic               err,
  output logic [EXP_W-1:0]   expire_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  state_t             state, state_nxt;
  logic               periodic_q, periodic_nxt;
  logic               count_nxt;
  logic               rst_counter_nxt;
  logic [CNT_W-1:0]   cmp_value_nxt;
  logic               irq_nxt;
  logic               overrun_nxt;
  logic               busy_nxt;
  logic               err_nxt;
  logic [EXP_W-1:0]   expire_cnt_nxt;
  logic               start_ok;
  logic               run_done;

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q, presc_nxt;
  logic [PRESC_W-1:0] div, div_nxt;
`else
  logic               unused_prescale;
  assign unused_prescale = ^prescale;
`endif

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_nxt       = state;
    periodic_nxt    = periodic_q;
    cmp_value_nxt   = cmp_value;
    irq_nxt         = irq;
    overrun_nxt     = overrun;
    expire_cnt_nxt  = expire_cnt;
    count_nxt       = 1'b0;
    rst_counter_nxt = 1'b0;
    busy_nxt        = 1'b0;
    err_nxt         = 1'b0;
    start_ok        = 1'b0;
    run_done        = 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
    presc_nxt       = presc_q;
    div_nxt         = '0;
`endif

    // A start that coincides with stop is dropped; a zero period is rejected.
    start_ok = start && (period != '0) && !stop;
    err_nxt  = start && (period == '0);
    run_done = (state == RUN) && done;

    case (state)
      IDLE, EXPIRED: begin
        if (start_ok) state_nxt = ARM;
      end
      ARM: begin
        if (stop)          state_nxt = IDLE;
        else if (start_ok) state_nxt = ARM;
        else               state_nxt = RUN;
      end
      RUN: begin
        if (stop)                      state_nxt = IDLE;
        else if (start_ok)             state_nxt = ARM;
        else if (done && !periodic_q)  state_nxt = EXPIRED;
      end
      default: state_nxt = IDLE;
    endcase

    if (irq_ack) irq_nxt = 1'b0;
    if (run_done) begin
      irq_nxt = 1'b1;
      if (irq && !irq_ack) overrun_nxt = 1'b1;
      if (expire_cnt != EXP_MAX) expire_cnt_nxt = expire_cnt + EXP_W'(1);
    end

    // A valid start reloads the latches and clears the expiry bookkeeping.
    if (start_ok) begin
      cmp_value_nxt  = period;
      periodic_nxt   = periodic;
      overrun_nxt    = 1'b0;
      expire_cnt_nxt = '0;
`ifdef TIMER_CTRL_PRESCALE_EN
      presc_nxt      = prescale;
`endif
    end

    rst_counter_nxt = (state_nxt == ARM);
    busy_nxt        = (state_nxt == ARM) || (state_nxt == RUN);

`ifdef TIMER_CTRL_PRESCALE_EN
    // div tracks the prescaler phase of the cycle being registered; it restarts at 0 on each RUN entry.
    if ((state_nxt == RUN) && (state == RUN))
      div_nxt = (div == presc_q) ? '0 : div + PRESC_W'(1);
    count_nxt = (state_nxt == RUN) && (div_nxt == '0);
`else
    count_nxt = (state_nxt == RUN);
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      periodic_q  <= 1'b0;
      count       <= 1'b0;
      rst_counter <= 1'b0;
      cmp_value   <= '0;
      irq         <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      expire_cnt  <= '0;
    end else begin
      state       <= state_nxt;
      periodic_q  <= periodic_nxt;
      count       <= count_nxt;
      rst_counter <= rst_counter_nxt;
      cmp_value   <= cmp_value_nxt;
      irq         <= irq_nxt;
      overrun     <= overrun_nxt;
      busy        <= busy_nxt;
      err         <= err_nxt;
      expire_cnt  <= expire_cnt_nxt;
    end
  end

`ifdef TIMER_CTRL_PRESCALE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      div     <= '0;
    end else begin
      presc_q <= presc_nxt;
      div     <= div_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl with hand-computed expectations.
module tb_timer_ctrl;

  localparam int unsigned CNT_W   = 64;
  localparam int unsigned EXP_W   = 16;
  localparam int unsigned PRESC_W = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic               periodic;
  logic [CNT_W-1:0]   period;
  logic [PRESC_W-1:0] prescale;
  logic               irq_ack;
  logic               done;
  logic               count;
  logic               rst_counter;
  logic [CNT_W-1:0]   cmp_value;
  logic               irq;
  logic               overrun;
  logic               busy;
  logic               err;
  logic [EXP_W-1:0]   expire_cnt;

  int n_checks;
  int n_fail;

  timer_ctrl #(.CNT_W(CNT_W), .EXP_W(EXP_W), .PRESC_W(PRESC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .periodic   (periodic),
    .period     (period),
    .prescale   (prescale),
    .irq_ack    (irq_ack),
    .done       (done),
    .count      (count),
    .rst_counter(rst_counter),
    .cmp_value  (cmp_value),
    .irq        (irq),
    .overrun    (overrun),
    .busy       (busy),
    .err        (err),
    .expire_cnt (expire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] p, input logic per, input logic [PRESC_W-1:0] ps);
    start = 1'b1; period = p; periodic = per; prescale = ps;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".count"},       64'(count),       64'd0);
    check({tag, ".rst_counter"}, 64'(rst_counter), 64'd0);
    check({tag, ".cmp_value"},   cmp_value,        64'd0);
    check({tag, ".irq"},         64'(irq),         64'd0);
    check({tag, ".overrun"},     64'(overrun),     64'd0);
    check({tag, ".busy"},        64'(busy),        64'd0);
    check({tag, ".err"},         64'(err),         64'd0);
    check({tag, ".expire_cnt"},  64'(expire_cnt),  64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0;
    period = '0; prescale = '0; irq_ack = 1'b0; done = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // One-shot, period 5.
    pulse_start(64'd5, 1'b0, 8'd0);
    check("os.arm.rst_counter", 64'(rst_counter), 64'd1);
    check("os.arm.busy",        64'(busy),        64'd1);
    check("os.arm.count",       64'(count),       64'd0);
    check("os.arm.cmp_value",   cmp_value,        64'd5);
    tick();
    check("os.run.rst_counter", 64'(rst_counter), 64'd0);
    check("os.run.count",       64'(count),       64'd1);
    tick();
    check("os.run2.count",      64'(count),       64'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("os.exp.irq",         64'(irq),         64'd1);
    check("os.exp.count",       64'(count),       64'd0);
    check("os.exp.expire_cnt",  64'(expire_cnt),  64'd1);
    check("os.exp.busy",        64'(busy),        64'd0);
    tick();
    check("os.exp2.count",      64'(count),       64'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("os.done_ignored.expire_cnt", 64'(expire_cnt), 64'd1);
    check("os.done_ignored.overrun",    64'(overrun),    64'd0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("os.ack.irq", 64'(irq), 64'd0);

    // Periodic, period 3, three unacknowledged expiries.
    pulse_start(64'd3, 1'b1, 8'd0);
    check("per.arm.expire_cnt", 64'(expire_cnt), 64'd0);
    tick();
    check("per.run.count", 64'(count), 64'd1);
    done = 1'b1;
    tick();
    check("per.d1.irq",     64'(irq),     64'd1);
    check("per.d1.overrun", 64'(overrun), 64'd0);
    tick();
    check("per.d2.overrun",    64'(overrun),    64'd1);
    check("per.d2.expire_cnt", 64'(expire_cnt), 64'd2);
    tick();
    done = 1'b0;
    check("per.d3.expire_cnt", 64'(expire_cnt), 64'd3);
    check("per.d3.count",      64'(count),      64'd1);
    check("per.d3.busy",       64'(busy),       64'd1);

    // Stop keeps irq and overrun.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop.busy",    64'(busy),    64'd0);
    check("stop.count",   64'(count),   64'd0);
    check("stop.irq",     64'(irq),     64'd1);
    check("stop.overrun", 64'(overrun), 64'd1);

    // Zero period start is rejected.
    pulse_start(64'd0, 1'b0, 8'd0);
    check("zero.err",       64'(err),  64'd1);
    check("zero.busy",      64'(busy), 64'd0);
    check("zero.cmp_value", cmp_value, 64'd3);
    check("zero.overrun",   64'(overrun), 64'd1);
    tick();
    check("zero.err_clear", 64'(err), 64'd0);

    // done coincident with irq_ack while irq pending.
    pulse_start(64'd7, 1'b1, 8'd0);
    check("ack.start.overrun", 64'(overrun), 64'd0);
    tick();
    done = 1'b1; irq_ack = 1'b1;
    tick();
    done = 1'b0; irq_ack = 1'b0;
    check("ack.coinc.irq",        64'(irq),        64'd1);
    check("ack.coinc.overrun",    64'(overrun),    64'd0);
    check("ack.coinc.expire_cnt", 64'(expire_cnt), 64'd1);

    // start and stop together while running.
    start = 1'b1; stop = 1'b1; period = 64'd9;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss.busy",        64'(busy),        64'd0);
    check("ss.count",       64'(count),       64'd0);
    check("ss.rst_counter", 64'(rst_counter), 64'd0);
    check("ss.cmp_value",   cmp_value,        64'd7);

    // Asynchronous reset in the middle of RUN.
    pulse_start(64'd4, 1'b1, 8'd0);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("ar.pre.count", 64'(count), 64'd1);
    check("ar.pre.irq",   64'(irq),   64'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    rst = 1'b0;
    tick();

    // Expiry counter saturation with done held high in periodic mode.
    pulse_start(64'd2, 1'b1, 8'd0);
    tick();
    done = 1'b1;
    repeat (65540) tick();
    done = 1'b0;
    check("sat.expire_cnt", 64'(expire_cnt), 64'hFFFF);
    tick();
    check("sat.hold",       64'(expire_cnt), 64'hFFFF);

    // Prescaler pattern with prescale 2 (ignored when the divider is not built).
    pulse_start(64'd5, 1'b1, 8'd2);
    check("presc.arm.count",      64'(count),      64'd0);
    check("presc.arm.expire_cnt", 64'(expire_cnt), 64'd0);
    for (int i = 0; i < 7; i++) begin
      logic exp_cnt;
      tick();
`ifdef TIMER_CTRL_PRESCALE_EN
      exp_cnt = ((i % 3) == 0);
`else
      exp_cnt = 1'b1;
`endif
      check($sformatf("presc.count[%0d]", i), 64'(count), 64'(exp_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Control unit that drives the timer datapath and consumes its `done` pulse. It latches a compare period, arms the datapath, and gates counting in one-shot or periodic mode. It converts each expiry into a level interrupt with an acknowledge handshake, overrun detection and a saturating expiry count. It sits between the CPU-side register interface and the timer datapath.

## Interface
- `CNT_W`, 64, width of period and `cmp_value`
- `EXP_W`, 16, width of expiry counter
- `PRESC_W`, 8, prescaler width; used only with `TIMER_CTRL_PRESCALE_EN`

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle strobe; arm/re-arm with `period`
- `stop`  in  1  one-cycle strobe; halt counting
- `periodic`  in  1  sampled with `start`; 1 = auto-reload, 0 = one-shot
- `period`  in  CNT_W  compare period, sampled with `start`
- `prescale`  in  PRESC_W  sampled with `start` (macro only)
- `irq_ack`  in  1  one-cycle strobe; clears `irq`
- `done`  in  1  expiry pulse from the datapath
- `count`  out  1  count enable to the datapath
- `rst_counter`  out  1  datapath counter clear
- `cmp_value`  out  CNT_W  latched period to the datapath
- `irq`  out  1  level interrupt
- `overrun`  out  1  sticky; expiry while `irq` is pending
- `busy`  out  1  state is ARM or RUN
- `err`  out  1  one-cycle pulse; `start` rejected
- `expire_cnt`  out  EXP_W  saturating expiry count

## Operation
- States: IDLE, ARM, RUN, EXPIRED.
- IDLE to ARM on `start` with `period` != 0:
  - latch `cmp_value`, `periodic` and `prescale`
  - clear `overrun` and `expire_cnt`
- `start` with `period`==0 in any state:
  - ignored
  - `err` pulses 1 cycle
  - state and latches unchanged
- ARM lasts exactly 1 cycle: `rst_counter`=1, `count`=0. Then go to RUN.
- RUN: `count`=1 every cycle, or gated by the prescaler when the macro is enabled.
- `done` sampled high in RUN:
  - `irq`←1
  - if `irq` was already 1 and `irq_ack` is not high this cycle, `overrun`←1
  - `expire_cnt`←`expire_cnt`+1, saturating at 2^EXP_W−1
  - periodic: stay in RUN; the datapath self-clears its counter
  - one-shot: go to EXPIRED, `count`=0
- `done` outside RUN is ignored.
- EXPIRED behaves like IDLE but keeps the latched values. `start` goes to ARM.
- `start` (valid) in ARM or RUN: restart via ARM and reload latches.
- `stop` in ARM, RUN or EXPIRED: go to IDLE. `irq` and `overrun` are kept.
- `stop` and `start` in the same cycle: `stop` wins and `start` is dropped.
- `irq_ack` clears `irq` the next cycle. If `done` and `irq_ack` coincide, `irq` stays 1 and `overrun` is not set.
- `overrun` clears only on reset or on a valid `start`.

## Timing
- All outputs are registered.
- Reset values:
  - `count`=0, `rst_counter`=0, `cmp_value`=0
  - `irq`=0, `overrun`=0, `busy`=0, `err`=0, `expire_cnt`=0
  - state IDLE
- `start` sampled at edge N:
  - `rst_counter`=1 and `busy`=1 in cycle N+1
  - `count`=1 from cycle N+2
- `done` sampled at edge M: `irq`=1 from M+1.
  - One-shot: `count`=0 from M+1.
- `irq_ack` at edge K: `irq`=0 from K+1.
- `stop` at edge S: `count`=0 and `busy`=0 from S+1.
- Asynchronous reset mid-operation forces all reset values immediately, independent of `clk`.

## Configuration
- Macro: `TIMER_CTRL_PRESCALE_EN`.
- Defined:
  - an internal PRESC_W-bit divider runs in RUN
  - `count`=1 for one cycle every `prescale`+1 cycles
  - `prescale`=0 gives `count`=1 every cycle
  - the divider clears on entry to ARM
- Undefined:
  - `prescale` is ignored and the divider is absent
  - `count`=1 every RUN cycle

## Test plan
- Reset then one-shot `start` with `period`=5:
  - `rst_counter` high 1 cycle, then `count`=1
  - on `done`: `irq`=1, `count`=0 next cycle, `expire_cnt`=1, state EXPIRED
- Periodic with `period`=3, three `done` pulses, no ack:
  - `irq`=1 after the first pulse
  - `overrun`=1 after the second pulse
  - `expire_cnt`=3, `count` stays 1
- `start` with `period`=0 from IDLE: `err` pulses 1 cycle, `busy`=0, `cmp_value` unchanged.
- `done` coincident with `irq_ack` while `irq`=1: `irq` stays 1, `overrun` stays 0.
- `start` and `stop` in the same cycle while RUN: IDLE next cycle, `count`=0.
- Reset asserted asynchronously mid-RUN: all outputs 0 before the next edge.
- With the macro and `prescale`=2: `count` pattern 1,0,0 repeating.
